// File: rtl/ss_ramp_pkg.sv
// Shared state type and default widths/steps for the soft-start ramp timer.
package ss_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        FULL    = 2'd2,
        RAMP_DN = 2'd3
    } ss_state_t;

    localparam int unsigned SS_CNT_W     = 27;
    localparam int unsigned SS_TMR_W     = 8;
    localparam int unsigned SS_IN_W      = 16;
    localparam int unsigned SS_STEP      = 1;
    localparam int unsigned SS_FAST_STEP = 256;
    localparam int unsigned SS_SOFT_STOP = 1;

endpackage

// File: rtl/ss_scale.sv
// Registered signed scaler: term_out = floor(term_in * ss_tmr / 2^TMR_W),
// bypassed to term_in in FULL and forced to zero in IDLE.
module ss_scale
    import ss_ramp_pkg::*;
#(
    parameter int unsigned IN_W  = SS_IN_W,
    parameter int unsigned TMR_W = SS_TMR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  ss_state_t              state,
    input  logic [TMR_W-1:0]       ss_tmr,
    input  logic signed [IN_W-1:0] term_in,
    output logic signed [IN_W-1:0] term_out
);

    localparam int unsigned PROD_W = IN_W + TMR_W + 1;

    logic signed [PROD_W-1:0] term_ext;
    logic signed [PROD_W-1:0] tmr_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_unused;

    assign term_ext = {{(TMR_W + 1){term_in[IN_W-1]}}, term_in};
    assign tmr_ext  = {{IN_W{1'b0}}, 1'b0, ss_tmr};
    assign prod     = term_ext * tmr_ext;

    // Taking the bits above TMR_W of a two's-complement product is the
    // arithmetic shift, i.e. truncation toward -inf.
    assign prod_unused = ^{prod[PROD_W-1], prod[TMR_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_out <= '0;
        end else begin
            case (state)
                IDLE:    term_out <= '0;
                FULL:    term_out <= term_in;
                default: term_out <= prod[TMR_W +: IN_W];
            endcase
        end
    end

endmodule

// File: rtl/soft_start_ramp.sv
// Soft-start/soft-stop ramp timer with built-in term scaler.
// Define SS_FAST_SIM_EN to use FAST_STEP instead of STEP for short simulations.
module soft_start_ramp
    import ss_ramp_pkg::*;
#(
    parameter int unsigned CNT_W     = SS_CNT_W,
    parameter int unsigned TMR_W     = SS_TMR_W,
    parameter int unsigned IN_W      = SS_IN_W,
    parameter int unsigned STEP      = SS_STEP,
    parameter int unsigned FAST_STEP = SS_FAST_STEP,
    parameter int unsigned SOFT_STOP = SS_SOFT_STOP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   hold,
    input  logic                   clr,
    input  logic signed [IN_W-1:0] term_in,
    output logic [TMR_W-1:0]       ss_tmr,
    output logic                   ramping,
    output logic                   full,
    output logic signed [IN_W-1:0] term_out
);

`ifdef SS_FAST_SIM_EN
    localparam int unsigned STEP_SEL = FAST_STEP;
`else
    localparam int unsigned STEP_SEL = STEP;
`endif

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_SEL);

    // A step below one ss_tmr LSB guarantees the increment can never wrap.
    if (64'(STEP_SEL) >= (64'd1 << (CNT_W - TMR_W))) begin : g_step_chk
        $error("soft_start_ramp: step must be < 2^(CNT_W-TMR_W)");
    end

    ss_state_t        state;
    ss_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmr_top;
    logic             tmr_top_inc;

    assign ss_tmr      = cnt[CNT_W-1 -: TMR_W];
    assign cnt_inc     = cnt + STEP_C;
    assign tmr_top     = &cnt[CNT_W-1 -: TMR_W];
    assign tmr_top_inc = &cnt_inc[CNT_W-1 -: TMR_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (en) state_nxt = RAMP_UP;
                end
                RAMP_UP, FULL: begin
                    if (!en) begin
                        if (SOFT_STOP != 0) begin
                            state_nxt = RAMP_DN;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (state == RAMP_UP) begin
                        // Re-entry from RAMP_DN can land with ss_tmr already saturated.
                        if (tmr_top) begin
                            state_nxt = FULL;
                        end else begin
                            cnt_nxt = cnt_inc;
                            if (tmr_top_inc) state_nxt = FULL;
                        end
                    end
                end
                RAMP_DN: begin
                    if (en) begin
                        state_nxt = RAMP_UP;
                    end else if (cnt < STEP_C) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - STEP_C;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ramping <= 1'b0;
            full    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ramping <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);
            full    <= (state_nxt == FULL);
        end
    end

    ss_scale #(
        .IN_W  (IN_W),
        .TMR_W (TMR_W)
    ) u_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .ss_tmr   (ss_tmr),
        .term_in  (term_in),
        .term_out (term_out)
    );

endmodule

// File: tb/tb_soft_start_ramp.sv
// Self-checking bench for soft_start_ramp against a cycle-level behavioural model.
module tb_soft_start_ramp;

    localparam int CNT_W = 12;
    localparam int TMR_W = 4;
    localparam int IN_W  = 16;
    localparam int SHIFT = CNT_W - TMR_W;
    localparam int TMAX  = (1 << TMR_W) - 1;
`ifdef SS_FAST_SIM_EN
    localparam int STEP_TB = 16;
`else
    localparam int STEP_TB = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic                   hold = 1'b0;
    logic                   clr = 1'b0;
    logic signed [IN_W-1:0] term_in = '0;
    logic [TMR_W-1:0]       ss_tmr;
    logic                   ramping;
    logic                   full;
    logic signed [IN_W-1:0] term_out;

    int errors = 0;
    int checks = 0;

    // Model: counter value plus three mutually exclusive mode flags (none set = idle).
    int m_cnt  = 0;
    bit m_up   = 0;
    bit m_dn   = 0;
    bit m_full = 0;
    int m_term = 0;

    soft_start_ramp #(
        .CNT_W     (CNT_W),
        .TMR_W     (TMR_W),
        .IN_W      (IN_W),
        .STEP      (1),
        .FAST_STEP (16),
        .SOFT_STOP (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .hold     (hold),
        .clr      (clr),
        .term_in  (term_in),
        .ss_tmr   (ss_tmr),
        .ramping  (ramping),
        .full     (full),
        .term_out (term_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_scale(input int t, input int k);
        int p;
        int m;
        p = t * k;
        m = ((p % (1 << TMR_W)) + (1 << TMR_W)) % (1 << TMR_W);
        return (p - m) / (1 << TMR_W);
    endfunction

    function automatic int m_tmr();
        return m_cnt / (1 << SHIFT);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_up = 0; m_dn = 0; m_full = 0; m_term = 0;
    endtask

    task automatic model_step();
        if (m_full)              m_term = int'(term_in);
        else if (!m_up && !m_dn) m_term = 0;
        else                     m_term = floor_scale(int'(term_in), m_tmr());
        if (clr) begin
            model_reset_cnt();
        end else if (hold) begin
        end else if (!m_up && !m_dn && !m_full) begin
            m_cnt = 0;
            if (en) m_up = 1;
        end else if (m_up || m_full) begin
            if (!en) begin
                m_up = 0; m_full = 0; m_dn = 1;
            end else if (m_up) begin
                if (m_tmr() != TMAX) m_cnt = m_cnt + STEP_TB;
                if (m_tmr() == TMAX) begin m_up = 0; m_full = 1; end
            end
        end else begin
            if (en) begin
                m_dn = 0; m_up = 1;
            end else if (m_cnt < STEP_TB) begin
                m_cnt = 0; m_dn = 0;
            end else begin
                m_cnt = m_cnt - STEP_TB;
            end
        end
    endtask

    task automatic model_reset_cnt();
        m_cnt = 0; m_up = 0; m_dn = 0; m_full = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/ss_tmr"},   ss_tmr,            m_tmr());
        check({tag, "/ramping"},  ramping,           (m_up || m_dn) ? 1 : 0);
        check({tag, "/full"},     full,              m_full ? 1 : 0);
        check({tag, "/term_out"}, $signed(term_out), m_term);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        term_in = IN_W'($urandom);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit half_done;
        int tmr_frozen;

        // Reset state
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle");

        // Ramp from IDLE to FULL, with the half-scale point probed on the way
        en = 1'b1;
        half_done = 0;
        n = 0;
        while (!m_full && n < 6000) begin
            if (!half_done && m_up && m_tmr() == 8) begin
                term_in = -16'sd1000;
                tick("ramp1");
                n++;
                check("scale_half", $signed(term_out), -500);
                half_done = 1;
            end else begin
                tick("ramp1");
                n++;
            end
        end
        check("ramp1_full", full, 1);
        check("ramp1_clks", n, 1 + 'hF00 / STEP_TB);
        check("ramp1_tmr", ss_tmr, TMAX);

        for (int i = 0; i < 100; i++) tick("full_hold");
        term_in = -16'sd1000;
        tick("full_bypass");
        check("scale_full", $signed(term_out), -1000);

        // Soft stop down to the midpoint, then resume upward without losing cnt
        en = 1'b0;
        n = 0;
        while (m_cnt != 'h800 && n < 6000) begin
            tick("down1");
            check("down1_ramping", ramping, 1);
            n++;
        end
        en = 1'b1;
        tick("resume");
        check("resume_tmr", ss_tmr, 8);
        check("resume_ramping", ramping, 1);
        n = 0;
        while (!m_full && n < 6000) begin tick("ramp2"); n++; end
        check("ramp2_full", full, 1);

        // Full soft stop to IDLE without underflow
        en = 1'b0;
        n = 0;
        while ((m_dn || m_full) && n < 6000) begin
            tick("down2");
            if (m_dn) check("down2_ramping", ramping, 1);
            n++;
        end
        check("down2_idle_ramping", ramping, 0);
        check("down2_idle_tmr", ss_tmr, 0);
        for (int i = 0; i < 5; i++) tick("idle2");

        // clr beats hold while ramping
        en = 1'b1;
        for (int i = 0; i < 600 / STEP_TB + 20; i++) tick("ramp3");
        clr = 1'b1;
        hold = 1'b1;
        tick("clr_hold");
        check("clr_tmr", ss_tmr, 0);
        check("clr_ramping", ramping, 0);
        clr = 1'b0;
        hold = 1'b0;

        // hold alone freezes the counter
        for (int i = 0; i < 900 / STEP_TB + 5; i++) tick("ramp4");
        tmr_frozen = m_tmr();
        hold = 1'b1;
        for (int i = 0; i < 50; i++) tick("hold");
        check("hold_tmr", ss_tmr, tmr_frozen);
        check("hold_ramping", ramping, 1);
        hold = 1'b0;

        // Asynchronous reset mid-ramp, then re-ramp from zero
        for (int i = 0; i < 300 / STEP_TB; i++) tick("ramp5");
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400 / STEP_TB; i++) tick("reramp");

        // Randomised control phase
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) en = ($urandom % 4) != 0;
            hold = ($urandom % 16) == 0;
            clr  = ($urandom % 128) == 0;
            tick("random");
        end
        hold = 1'b0;
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
